bp_fe_lce_resp_arb: RTL and testbench
=====================================

Name: bp_fe_lce_resp_arb

Overview:
- Shares the single I$ LCE-to-CCE response channel between response producers in the FE LCE. Sources are the miss/request unit (coherence acks) and the command unit (invalidate acks, sync acks, writebacks).
- Round-robin arbitration with a locked grant: once a message is presented downstream it is held stable until consumed.
- Sits between the LCE sub-units and the lce_resp network port. Also reports per-source pending status and a drain/idle flag for the command unit's sync handling.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor configuration; supplies the lce_cce_resp width.
- num_src_p, 2, number of requesting sources (index 0 = command unit, 1 = request unit).
- msg_width_p, lce_cce_resp_width_lp, width of one response message.
- lock_watchdog_p, 64, cycles a locked grant may wait for yumi before the stall flag asserts.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- src_msg_i  in  num_src_p*msg_width_p  packed per-source messages, source i at [i*msg_width_p +: msg_width_p]
- src_v_i  in  num_src_p  per-source valid; held until the matching yumi
- src_yumi_o  out  num_src_p  one-hot (or zero) consume pulse back to sources
- block_i  in  1  suppresses new grants (e.g. network backpressure timeout); does not break a lock
- lce_resp_o  out  msg_width_p  granted message
- lce_resp_v_o  out  1  downstream valid
- lce_resp_yumi_i  in  1  downstream consume, legal only when lce_resp_v_o
- idle_o  out  1  no source valid and no lock held
- stall_o  out  1  locked grant exceeded lock_watchdog_p cycles

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: state = e_arb_idle, rr_ptr = 0, grant_r = 0, watchdog = 0. Outputs: lce_resp_v_o = 0, src_yumi_o = 0, stall_o = 0, idle_o = 1. lce_resp_o = 0 whenever v_o = 0.
- State e_arb_idle:
  - If any src_v_i and ~block_i: pick the first valid source at or after rr_ptr, wrapping modulo num_src_p.
  - Drive lce_resp_o/v_o from it in the same cycle (zero-latency path).
  - If lce_resp_yumi_i in that cycle: pulse src_yumi_o[pick], set rr_ptr = (pick+1) mod num_src_p, remain idle.
  - Otherwise: grant_r = pick, go to e_arb_locked.
- State e_arb_locked:
  - lce_resp_o = src_msg_i[grant_r] and lce_resp_v_o = 1, regardless of block_i and of other sources.
  - On lce_resp_yumi_i: src_yumi_o[grant_r] = 1, rr_ptr = grant_r+1 (wrapped), go to e_arb_idle, watchdog cleared.
- Re-arbitration: a new pick occurs only in the cycle after a yumi, so at most one message is consumed per cycle. Back-to-back messages from different sources produce one message per cycle when yumi is held high.
- block_i = 1 in idle: v_o = 0, no yumi, rr_ptr unchanged.
- src_v_i[grant_r] dropping while locked is a protocol violation. It is flagged by a simulation assertion; RTL keeps v_o = 1 and the lock.
- yumi without v_o is also asserted against and has no effect on state.
- Watchdog:
  - Counts cycles in e_arb_locked without yumi, saturating at lock_watchdog_p.
  - stall_o = (count == lock_watchdog_p).
  - Cleared on yumi or reset.
- Reset mid-operation: lock dropped and no yumi issued; sources must re-present.
- rr_ptr width is `BSG_SAFE_CLOG2(num_src_p). Wrap is explicit, not power-of-two truncation, so num_src_p = 3 works.
- idle_o = (state == e_arb_idle) & ~|src_v_i.

Decomposition:
- Shared package (bp_fe_icache_pkg): bp_fe_lce_resp_arb_state_e {e_arb_idle, e_arb_locked}, and the source-index constants for the command unit (0) and the request unit (1).
- One sub-module, bp_fe_rr_pick: combinational rotate-priority-encode over num_src_p. Inputs are the valid vector and rr_ptr; outputs are the pick index and pick_v.
- The FSM, lock register, pointer and watchdog live in the top module.

Test Plan:
- Reset then src_v_i = 2'b10, yumi held 1 → v_o = 1 in the same cycle, lce_resp_o = src 1 msg, src_yumi_o = 2'b10, rr_ptr = 0.
- Both valid continuously, yumi = 1 every cycle → grants alternate 0, 1, 0, 1; four messages in four cycles.
- src 0 valid, yumi = 0 for 5 cycles, src 1 raises valid in cycle 2 → lce_resp_o stays src 0 msg for all 5 cycles. On yumi in cycle 6, src_yumi_o = 2'b01; src 1 is granted in cycle 7.
- block_i = 1 with src_v_i = 2'b11 → v_o = 0 and no yumi. Assert block_i while already locked → v_o stays 1 and the yumi completes normally.
- lock_watchdog_p = 4, locked, no yumi → stall_o rises after the 4th waiting cycle and clears on the cycle after yumi.
- reset_i pulsed while locked on src 1 → next cycle state idle, v_o = 0, rr_ptr = 0, no src_yumi_o pulse.

Source files
------------

// File: rtl/bp_fe_icache_pkg.sv
// Shared I$ front-end definitions: configuration selector, response width,
// arbiter state encoding and LCE response source indices.
package bp_fe_icache_pkg;

  typedef enum logic {e_bp_inv_cfg} bp_params_e;

  localparam int lce_id_width_gp     = 4;
  localparam int cce_id_width_gp     = 4;
  localparam int resp_type_width_gp  = 3;
  localparam int paddr_width_gp      = 40;

  // Response message = type + source LCE + destination CCE + physical address.
  function automatic int lce_cce_resp_width(input bp_params_e cfg);
    int width;
    width = resp_type_width_gp + lce_id_width_gp + cce_id_width_gp + paddr_width_gp;
    if (cfg != e_bp_inv_cfg) width = 64;
    return width;
  endfunction

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    e_arb_idle,
    e_arb_locked
  } bp_fe_lce_resp_arb_state_e;

  localparam int cmd_src_idx_gp = 0;
  localparam int req_src_idx_gp = 1;

endpackage

// File: rtl/bp_fe_rr_pick.sv
// Rotating priority encoder: returns the first asserted valid at or after
// rr_ptr_i, wrapping modulo num_src_p.
module bp_fe_rr_pick
  import bp_fe_icache_pkg::*;
#(
  parameter  int num_src_p    = 2,
  localparam int ptr_width_lp = safe_clog2(num_src_p)
) (
  input  logic [num_src_p-1:0]    v_i,
  input  logic [ptr_width_lp-1:0] rr_ptr_i,
  output logic [ptr_width_lp-1:0] pick_o,
  output logic                    pick_v_o
);

  localparam logic [ptr_width_lp:0] num_src_lp = (ptr_width_lp+1)'(num_src_p);

  logic [2*num_src_p-1:0] v_dbl;
  logic [num_src_p-1:0]   v_rot;
  logic [ptr_width_lp:0]  idx_sum;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a signal unassigned (no latch inferred).
  always_comb begin
    v_dbl    = {v_i, v_i};
    v_rot    = v_dbl[rr_ptr_i +: num_src_p];
    pick_o   = '0;
    pick_v_o = 1'b0;
    idx_sum  = '0;
    // Scan from the far end so the nearest valid to rr_ptr_i wins.
    for (int k = num_src_p - 1; k >= 0; k--) begin
      if (v_rot[k]) begin
        idx_sum = {1'b0, rr_ptr_i} + (ptr_width_lp+1)'(k);
        if (idx_sum >= num_src_lp) idx_sum = idx_sum - num_src_lp;
        pick_o   = idx_sum[ptr_width_lp-1:0];
        pick_v_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_fe_lce_resp_arb.sv
// Round-robin arbiter sharing the FE LCE-to-CCE response channel; a presented
// message is locked until the network consumes it.
module bp_fe_lce_resp_arb
  import bp_fe_icache_pkg::*;
#(
  parameter  bp_params_e bp_params_p     = e_bp_inv_cfg,
  parameter  int         num_src_p       = 2,
  parameter  int         msg_width_p     = lce_cce_resp_width(bp_params_p),
  parameter  int         lock_watchdog_p = 64,
  localparam int         ptr_width_lp    = safe_clog2(num_src_p),
  localparam int         wd_width_lp     = safe_clog2(lock_watchdog_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_src_p*msg_width_p-1:0] src_msg_i,
  input  logic [num_src_p-1:0]             src_v_i,
  output logic [num_src_p-1:0]             src_yumi_o,
  input  logic                             block_i,
  output logic [msg_width_p-1:0]           lce_resp_o,
  output logic                             lce_resp_v_o,
  input  logic                             lce_resp_yumi_i,
  output logic                             idle_o,
  output logic                             stall_o
);

  localparam logic [wd_width_lp-1:0]  wd_max_lp   = wd_width_lp'(lock_watchdog_p);
  localparam logic [ptr_width_lp-1:0] last_src_lp = ptr_width_lp'(num_src_p - 1);

  bp_fe_lce_resp_arb_state_e state_r, state_n;
  logic [ptr_width_lp-1:0] grant_r, grant_n;
  logic [ptr_width_lp-1:0] rr_ptr_r, rr_ptr_n;
  logic [wd_width_lp-1:0]  wd_cnt_r, wd_cnt_n;

  logic [ptr_width_lp-1:0] pick;
  logic                    pick_v;
  logic [ptr_width_lp-1:0] sel;
  logic [num_src_p-1:0][msg_width_p-1:0] src_msg;

  assign src_msg = src_msg_i;

  // Explicit wrap so non-power-of-two source counts rotate correctly.
  function automatic logic [ptr_width_lp-1:0] wrap_inc(input logic [ptr_width_lp-1:0] p);
    return (p == last_src_lp) ? '0 : p + ptr_width_lp'(1);
  endfunction

  bp_fe_rr_pick #(
    .num_src_p(num_src_p)
  ) rr_pick (
    .v_i      (src_v_i),
    .rr_ptr_i (rr_ptr_r),
    .pick_o   (pick),
    .pick_v_o (pick_v)
  );

  // NOTE: sequential state uses non-blocking assignments; reset is sampled
  // synchronously on the clock edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_arb_idle;
      grant_r  <= '0;
      rr_ptr_r <= '0;
      wd_cnt_r <= '0;
    end else begin
      state_r  <= state_n;
      grant_r  <= grant_n;
      rr_ptr_r <= rr_ptr_n;
      wd_cnt_r <= wd_cnt_n;
    end
  end

  always_comb begin
    state_n      = state_r;
    grant_n      = grant_r;
    rr_ptr_n     = rr_ptr_r;
    wd_cnt_n     = wd_cnt_r;
    sel          = grant_r;
    lce_resp_v_o = 1'b0;
    src_yumi_o   = '0;

    unique case (state_r)
      e_arb_idle: begin
        wd_cnt_n = '0;
        if (pick_v && !block_i) begin
          sel          = pick;
          lce_resp_v_o = 1'b1;
          if (lce_resp_yumi_i) begin
            src_yumi_o[pick] = 1'b1;
            rr_ptr_n         = wrap_inc(pick);
          end else begin
            grant_n = pick;
            state_n = e_arb_locked;
          end
        end
      end
      e_arb_locked: begin
        // Lock holds regardless of block_i or other requesters.
        sel          = grant_r;
        lce_resp_v_o = 1'b1;
        if (lce_resp_yumi_i) begin
          src_yumi_o[grant_r] = 1'b1;
          rr_ptr_n            = wrap_inc(grant_r);
          state_n             = e_arb_idle;
          wd_cnt_n            = '0;
        end else if (wd_cnt_r != wd_max_lp) begin
          wd_cnt_n = wd_cnt_r + wd_width_lp'(1);
        end
      end
      default: state_n = e_arb_idle;
    endcase

    // A reset cycle drops the lock without consuming anything.
    if (reset_i) begin
      lce_resp_v_o = 1'b0;
      src_yumi_o   = '0;
    end
  end

  assign lce_resp_o = lce_resp_v_o ? src_msg[sel] : '0;
  assign stall_o    = (wd_cnt_r == wd_max_lp);
  assign idle_o     = (state_r == e_arb_idle) && !(|src_v_i);

  lock_src_held_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_r == e_arb_locked) |-> src_v_i[grant_r]);

  yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (reset_i)
    lce_resp_yumi_i |-> lce_resp_v_o);

endmodule

// File: tb/tb_bp_fe_lce_resp_arb.sv
// Self-checking bench for bp_fe_lce_resp_arb: directed scenarios followed by
// random traffic, all compared against a queue-free behavioural model.
module tb_bp_fe_lce_resp_arb;
  import bp_fe_icache_pkg::*;

  localparam int num_src_lp   = 2;
  localparam int msg_width_lp = lce_cce_resp_width(e_bp_inv_cfg);
  localparam int wd_lp        = 4;

  logic                              clk_i = 1'b0;
  logic                              reset_i;
  logic [num_src_lp*msg_width_lp-1:0] src_msg_i;
  logic [num_src_lp-1:0]             src_v_i;
  logic [num_src_lp-1:0]             src_yumi_o;
  logic                              block_i;
  logic [msg_width_lp-1:0]           lce_resp_o;
  logic                              lce_resp_v_o;
  logic                              lce_resp_yumi_i;
  logic                              idle_o;
  logic                              stall_o;

  always #5 clk_i = ~clk_i;

  bp_fe_lce_resp_arb #(
    .bp_params_p     (e_bp_inv_cfg),
    .num_src_p       (num_src_lp),
    .lock_watchdog_p (wd_lp)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .src_msg_i       (src_msg_i),
    .src_v_i         (src_v_i),
    .src_yumi_o      (src_yumi_o),
    .block_i         (block_i),
    .lce_resp_o      (lce_resp_o),
    .lce_resp_v_o    (lce_resp_v_o),
    .lce_resp_yumi_i (lce_resp_yumi_i),
    .idle_o          (idle_o),
    .stall_o         (stall_o)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: which sources hold a pending message, which one (if
  // any) owns the channel, who has priority next, how long the owner waited.
  bit                      pend  [num_src_lp];
  logic [msg_width_lp-1:0] msg_q [num_src_lp];
  int                      held     = -1;
  int                      next_pri = 0;
  int                      waited   = 0;
  logic [msg_width_lp-1:0] saved_msg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int model_pick(input logic blk);
    int s;
    if (held >= 0) return held;
    if (blk) return -1;
    for (int k = 0; k < num_src_lp; k++) begin
      s = (next_pri + k) % num_src_lp;
      if (pend[s]) return s;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [num_src_lp-1:0] raise, input logic blk,
                       input logic want_yumi, input string tag);
    int                      pick;
    logic                    exp_v;
    logic                    yumi;
    logic                    any_pend;
    logic [63:0]             r;
    logic [msg_width_lp-1:0] exp_msg;
    logic [num_src_lp-1:0]   exp_yumi;
    @(negedge clk_i);
    any_pend = 1'b0;
    for (int i = 0; i < num_src_lp; i++) begin
      if (!pend[i] && raise[i]) begin
        pend[i]  = 1'b1;
        r        = {$urandom(), $urandom()};
        msg_q[i] = r[msg_width_lp-1:0];
      end
      src_v_i[i] = pend[i];
      src_msg_i[i*msg_width_lp +: msg_width_lp] = msg_q[i];
      any_pend |= pend[i];
    end
    block_i = blk;
    pick    = model_pick(blk);
    exp_v   = (pick >= 0);
    yumi    = want_yumi && exp_v;
    lce_resp_yumi_i = yumi;
    #1;
    exp_msg  = exp_v ? msg_q[pick] : '0;
    exp_yumi = yumi ? num_src_lp'(1 << pick) : '0;
    check({tag, ".v"},     64'(lce_resp_v_o), 64'(exp_v));
    check({tag, ".msg"},   64'(lce_resp_o),   64'(exp_msg));
    check({tag, ".yumi"},  64'(src_yumi_o),   64'(exp_yumi));
    check({tag, ".idle"},  64'(idle_o),       64'((held < 0) && !any_pend));
    check({tag, ".stall"}, 64'(stall_o),      64'(waited == wd_lp));
    if (yumi) begin
      pend[pick] = 1'b0;
      next_pri   = (pick + 1) % num_src_lp;
      held       = -1;
      waited     = 0;
    end else if (exp_v) begin
      if (held >= 0 && waited < wd_lp) waited++;
      held = pick;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_i);
    reset_i         = 1'b1;
    src_v_i         = '0;
    block_i         = 1'b0;
    lce_resp_yumi_i = 1'b0;
    for (int i = 0; i < num_src_lp; i++) pend[i] = 1'b0;
    repeat (n) @(posedge clk_i);
    #1 reset_i = 1'b0;
    held     = -1;
    next_pri = 0;
    waited   = 0;
  endtask

  initial begin
    reset_i         = 1'b1;
    src_msg_i       = '0;
    src_v_i         = '0;
    block_i         = 1'b0;
    lce_resp_yumi_i = 1'b0;
    for (int i = 0; i < num_src_lp; i++) begin
      pend[i]  = 1'b0;
      msg_q[i] = '0;
    end
    do_reset(2);

    // Reset state with nothing requesting.
    cycle(2'b00, 1'b0, 1'b0, "reset");

    // Zero-latency grant of the request unit, then rr_ptr back at 0.
    cycle(2'b10, 1'b0, 1'b1, "t1");
    check("t1.yumi_req", 64'(src_yumi_o[req_src_idx_gp]), 64'(1));
    cycle(2'b11, 1'b0, 1'b1, "t1b");
    check("t1b.yumi_cmd", 64'(src_yumi_o), 64'(2'b01));

    // Both continuously valid with yumi held: one message per cycle, alternating.
    for (int i = 0; i < 4; i++) begin
      cycle(2'b11, 1'b0, 1'b1, "t2");
      check("t2.alt", 64'(src_yumi_o), 64'((i % 2 == 0) ? 2'b10 : 2'b01));
    end
    cycle(2'b00, 1'b0, 1'b1, "t2.drain");

    // Locked on src 0 for five cycles while src 1 arrives.
    cycle(2'b01, 1'b0, 1'b0, "t3.c1");
    saved_msg = msg_q[cmd_src_idx_gp];
    cycle(2'b10, 1'b0, 1'b0, "t3.c2");
    check("t3.c2.hold", 64'(lce_resp_o), 64'(saved_msg));
    for (int i = 0; i < 3; i++) begin
      cycle(2'b00, 1'b0, 1'b0, "t3.cn");
      check("t3.cn.hold", 64'(lce_resp_o), 64'(saved_msg));
    end
    cycle(2'b00, 1'b0, 1'b1, "t3.c6");
    check("t3.c6.yumi", 64'(src_yumi_o), 64'(2'b01));
    cycle(2'b00, 1'b0, 1'b1, "t3.c7");
    check("t3.c7.yumi", 64'(src_yumi_o), 64'(2'b10));

    // block_i stops new grants but not an existing lock.
    cycle(2'b11, 1'b1, 1'b1, "t4.blk");
    check("t4.blk.v", 64'(lce_resp_v_o), 64'(0));
    cycle(2'b00, 1'b0, 1'b0, "t4.lock");
    cycle(2'b00, 1'b1, 1'b0, "t4.lockblk");
    check("t4.lockblk.v", 64'(lce_resp_v_o), 64'(1));
    cycle(2'b00, 1'b1, 1'b1, "t4.yumi");
    check("t4.yumi.src", 64'(src_yumi_o), 64'(2'b01));
    cycle(2'b00, 1'b0, 1'b1, "t4.drain");

    // Watchdog: stall after four waiting cycles, cleared after the yumi.
    cycle(2'b01, 1'b0, 1'b0, "t5.lock");
    for (int i = 0; i < 4; i++) begin
      cycle(2'b00, 1'b0, 1'b0, "t5.wait");
      check("t5.wait.stall", 64'(stall_o), 64'(0));
    end
    cycle(2'b00, 1'b0, 1'b0, "t5.stall");
    check("t5.stall.hi", 64'(stall_o), 64'(1));
    cycle(2'b00, 1'b0, 1'b1, "t5.yumi");
    cycle(2'b00, 1'b0, 1'b0, "t5.after");
    check("t5.after.lo", 64'(stall_o), 64'(0));

    // Reset while locked on src 1 (rr_ptr is 1 beforehand).
    cycle(2'b10, 1'b0, 1'b0, "t6.lock");
    cycle(2'b00, 1'b0, 1'b0, "t6.locked");
    do_reset(1);
    cycle(2'b00, 1'b0, 1'b0, "t6.post");
    check("t6.post.v",    64'(lce_resp_v_o), 64'(0));
    check("t6.post.yumi", 64'(src_yumi_o),   64'(0));
    cycle(2'b11, 1'b0, 1'b1, "t6.rr");
    check("t6.rr.cmd", 64'(src_yumi_o), 64'(2'b01));
    cycle(2'b00, 1'b0, 1'b1, "t6.drain");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(num_src_lp'($urandom()), ($urandom() % 5) == 0, 1'($urandom()), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
